// File: rtl/led_seq_pkg.sv
// Shared types and the fixed LED pattern table for the LED sequencer.
// Each table entry pairs an 8-bit pattern with its hold length in ticks.
package led_seq_pkg;

   typedef struct packed {
      logic [7:0] pattern;
      logic [7:0] hold;
   } led_entry_t;

   localparam int SEQ_DEPTH = 16;

   localparam led_entry_t SEQ_ROM [0:SEQ_DEPTH-1] = '{
      '{pattern: 8'h01, hold: 8'd1},
      '{pattern: 8'h02, hold: 8'd1},
      '{pattern: 8'h04, hold: 8'd1},
      '{pattern: 8'h08, hold: 8'd1},
      '{pattern: 8'h10, hold: 8'd1},
      '{pattern: 8'h20, hold: 8'd1},
      '{pattern: 8'h40, hold: 8'd1},
      '{pattern: 8'h80, hold: 8'd1},
      '{pattern: 8'hFF, hold: 8'd2},
      '{pattern: 8'h00, hold: 8'd2},
      '{pattern: 8'hAA, hold: 8'd1},
      '{pattern: 8'h55, hold: 8'd1},
      '{pattern: 8'hF0, hold: 8'd1},
      '{pattern: 8'h0F, hold: 8'd1},
      '{pattern: 8'h81, hold: 8'd0},
      '{pattern: 8'h00, hold: 8'd3}
   };

   // A hold of zero is treated as one tick so every entry is shown.
   function automatic logic [7:0] eff_hold(input logic [7:0] hold);
      return (hold == 8'd0) ? 8'd1 : hold;
   endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Clock-enable divider: tick is high for one cycle out of every TICK_DIV.
// TICK_DIV of 1 keeps tick high every cycle.
module led_tick_gen
   import led_seq_pkg::*;
#(
   parameter int TICK_DIV = 25
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] r_div_cnt;

   assign tick = (r_div_cnt == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_div_cnt <= '0;
      end else if (tick) begin
         r_div_cnt <= '0;
      end else begin
         r_div_cnt <= r_div_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/led_sequencer_top.sv
// Board-level LED sequencer: steps through a 16-entry pattern table,
// holding each entry for a programmed number of divider ticks.
module led_sequencer_top
   import led_seq_pkg::*;
#(
   parameter int TICK_DIV = 25
) (
   input  logic clk,
   input  logic rst,
   output logic LED0,
   output logic LED1,
   output logic LED2,
   output logic LED3,
   output logic LED4,
   output logic LED5,
   output logic LED6,
   output logic LED7
);

   logic       w_tick;
   logic [3:0] w_next_idx;
   logic [7:0] w_last_cnt;
   logic       w_advance;

   logic [7:0] r_hold_cnt;
   logic [3:0] r_idx;
   logic [7:0] r_led;

   led_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .tick (w_tick)
   );

   assign w_next_idx = r_idx + 4'd1;
   assign w_last_cnt = eff_hold(SEQ_ROM[r_idx].hold) - 8'd1;
   assign w_advance  = (r_hold_cnt == w_last_cnt);

   // The next pattern is loaded on the advancing tick edge itself,
   // so the LEDs change with no added latency.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hold_cnt <= 8'd0;
         r_idx      <= 4'd0;
         r_led      <= 8'h01;
      end else if (w_tick) begin
         if (w_advance) begin
            r_hold_cnt <= 8'd0;
            r_idx      <= w_next_idx;
            r_led      <= SEQ_ROM[w_next_idx].pattern;
         end else begin
            r_hold_cnt <= r_hold_cnt + 8'd1;
         end
      end
   end

   assign LED0 = r_led[0];
   assign LED1 = r_led[1];
   assign LED2 = r_led[2];
   assign LED3 = r_led[3];
   assign LED4 = r_led[4];
   assign LED5 = r_led[5];
   assign LED6 = r_led[6];
   assign LED7 = r_led[7];

endmodule

// File: tb/tb_led_sequencer_top.sv
// Self-checking bench: default-divider and TICK_DIV=1 instances checked
// every cycle against a loop-position model plus literal expectations.
`timescale 1ns/1ps
module tb_led_sequencer_top;

   logic clk;
   logic rst;
   logic a0, a1, a2, a3, a4, a5, a6, a7;
   logic b0, b1, b2, b3, b4, b5, b6, b7;
   logic [7:0] w_led_a;
   logic [7:0] w_led_b;

   int n_checks;
   int n_fail;
   int unsigned n_edge;

   assign w_led_a = {a7, a6, a5, a4, a3, a2, a1, a0};
   assign w_led_b = {b7, b6, b5, b4, b3, b2, b1, b0};

   led_sequencer_top u_dut (
      .clk  (clk),
      .rst  (rst),
      .LED0 (a0),
      .LED1 (a1),
      .LED2 (a2),
      .LED3 (a3),
      .LED4 (a4),
      .LED5 (a5),
      .LED6 (a6),
      .LED7 (a7)
   );

   led_sequencer_top #(
      .TICK_DIV (1)
   ) u_dut1 (
      .clk  (clk),
      .rst  (rst),
      .LED0 (b0),
      .LED1 (b1),
      .LED2 (b2),
      .LED3 (b3),
      .LED4 (b4),
      .LED5 (b5),
      .LED6 (b6),
      .LED7 (b7)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Rising edges since the last reset release.
   always @(posedge clk) begin
      if (rst) n_edge = 0;
      else     n_edge = n_edge + 1;
   end

   // Expected LEDs from ticks elapsed and cumulative entry durations.
   function automatic logic [7:0] model_led(input int unsigned n,
                                            input int unsigned div);
      int unsigned pat [16] = '{8'h01, 8'h02, 8'h04, 8'h08,
                                8'h10, 8'h20, 8'h40, 8'h80,
                                8'hFF, 8'h00, 8'hAA, 8'h55,
                                8'hF0, 8'h0F, 8'h81, 8'h00};
      int unsigned hld [16] = '{1, 1, 1, 1, 1, 1, 1, 1,
                                2, 2, 1, 1, 1, 1, 0, 3};
      int unsigned t;
      int unsigned h;
      t = (n / div) % 20;
      for (int k = 0; k < 16; k++) begin
         h = (hld[k] == 0) ? 1 : hld[k];
         if (t < h) return pat[k][7:0];
         t = t - h;
      end
      return 8'hXX;
   endfunction

   task automatic check(input string name, input logic [7:0] act,
                        input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at edge %0d: got %h expected %h",
                  name, n_edge, act, exp);
      end
   endtask

   // Continuous compare on the falling edge.
   always @(negedge clk) begin
      if (rst) begin
         check("reset_a", w_led_a, 8'h01);
         check("reset_b", w_led_b, 8'h01);
      end else begin
         check("model_a", w_led_a, model_led(n_edge, 25));
         check("model_b", w_led_b, model_led(n_edge, 1));
      end
   end

   task automatic run_to(input int unsigned target);
      while (n_edge < target) begin
         @(posedge clk);
         #1;
      end
   endtask

   int unsigned lit_edge [20] = '{24, 25, 50, 75, 175, 200, 250, 300,
                                  325, 349, 350, 375, 400, 424, 425,
                                  499, 500, 1000, 5000, 10000};
   logic [7:0]  lit_val  [20] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h80,
                                  8'hFF, 8'h00, 8'hAA, 8'h55, 8'h55,
                                  8'hF0, 8'h0F, 8'h81, 8'h81, 8'h00,
                                  8'h00, 8'h01, 8'h01, 8'h01, 8'h01};

   initial begin
      n_checks = 0;
      n_fail   = 0;
      n_edge   = 0;
      rst      = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("in_reset", w_led_a, 8'h01);
      @(negedge clk);
      #2;
      rst = 1'b0;

      run_to(1);
      check("div1_e1", w_led_b, 8'h02);
      check("div25_e1", w_led_a, 8'h01);
      run_to(7);
      check("div1_e7", w_led_b, 8'h80);
      run_to(8);
      check("div1_e8", w_led_b, 8'hFF);
      run_to(20);
      check("div1_loop", w_led_b, 8'h01);

      for (int i = 0; i < 20; i++) begin
         run_to(lit_edge[i]);
         check("table", w_led_a, lit_val[i]);
      end

      run_to(10310);
      check("pre_rst", w_led_a, 8'hAA);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst", w_led_a, 8'h01);
      check("async_rst1", w_led_b, 8'h01);
      repeat (2) @(posedge clk);
      @(negedge clk);
      #2;
      rst = 1'b0;
      run_to(24);
      check("post_e24", w_led_a, 8'h01);
      run_to(25);
      check("post_e25", w_led_a, 8'h02);
      run_to(60);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
